// File: rtl/pal2sel_pkg.sv
// pal2sel shared types: FSM state encoding and default geometry.
// Optional parity bit is enabled by defining PAL2SEL_PARITY_EN.
package pal2sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_DW  = 8;
  localparam int DEF_GAP = 1;

endpackage

// File: rtl/pal2sel_hold.sv
// pal2sel one-entry holding register with ready/overflow handshake.
// ready is the inverted full flag, kept directly in a flop.
module pal2sel_hold
  import pal2sel_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrb,
  input  logic [DW-1:0] db_in,
  input  logic          take,
  output logic          ready,
  output logic          ovf,
  output logic [DW-1:0] hold
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      ovf   <= 1'b0;
      hold  <= '0;
    end else begin
      ovf <= wrb & ~ready;
      if (wrb && ready) begin
        hold  <= db_in;
        ready <= 1'b0;
      end else if (take) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pal2sel.sv
// pal2sel parallel-to-serial link transmitter, MSB first, wra_n framed.
// Define PAL2SEL_PARITY_EN to append an even-parity bit to each frame.
module pal2sel
  import pal2sel_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int GAP = DEF_GAP
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          wrb,
  input  logic [DW-1:0] db_in,
  output logic          ready,
  output logic          dout,
  output logic          wra_n,
  output logic          ovf,
  output logic          busy
);

`ifdef PAL2SEL_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif
  localparam int BW = $clog2(DW + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] hold;
  logic [DW-1:0] sreg, sreg_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [3:0]    gcnt, gcnt_nxt;
  logic          dout_nxt, wra_n_nxt;
  logic          take, start;
`ifdef PAL2SEL_PARITY_EN
  logic          par, par_nxt;
`endif

  pal2sel_hold #(.DW(DW)) u_hold (
    .clk   (clka),
    .rst_n (rst_n),
    .wrb   (wrb),
    .db_in (db_in),
    .take  (take),
    .ready (ready),
    .ovf   (ovf),
    .hold  (hold)
  );

  assign busy = (state != ST_IDLE);

  // sreg holds only the bits still to be sent, left aligned
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bcnt_nxt  = bcnt;
    gcnt_nxt  = gcnt;
    dout_nxt  = dout;
    wra_n_nxt = wra_n;
    take      = 1'b0;
    start     = 1'b0;
`ifdef PAL2SEL_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      ST_IDLE: start = ~ready;
      ST_SHIFT: begin
        if (bcnt == BW'(FL - 1)) begin
          state_nxt = ST_GAP;
          wra_n_nxt = 1'b1;
          dout_nxt  = 1'b0;
          gcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt + 1'b1;
          sreg_nxt = {sreg[DW-2:0], 1'b0};
          dout_nxt = sreg[DW-1];
`ifdef PAL2SEL_PARITY_EN
          if (bcnt == BW'(DW - 1))
            dout_nxt = par;
`endif
        end
      end
      ST_GAP: begin
        if (gcnt == 4'(GAP - 1)) begin
          if (!ready) start = 1'b1;
          else state_nxt = ST_IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) begin
      take      = 1'b1;
      state_nxt = ST_SHIFT;
      sreg_nxt  = {hold[DW-2:0], 1'b0};
      bcnt_nxt  = '0;
      wra_n_nxt = 1'b0;
      dout_nxt  = hold[DW-1];
`ifdef PAL2SEL_PARITY_EN
      par_nxt   = ^hold;
`endif
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      dout  <= 1'b0;
      wra_n <= 1'b1;
`ifdef PAL2SEL_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      bcnt  <= bcnt_nxt;
      gcnt  <= gcnt_nxt;
      dout  <= dout_nxt;
      wra_n <= wra_n_nxt;
`ifdef PAL2SEL_PARITY_EN
      par   <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pal2sel.sv
// Self-checking bench for pal2sel: bit tables, scoreboard receiver,
// back-to-back, overflow, mid-frame reset and a GAP=3 instance.
module tb_pal2sel;

`ifdef PAL2SEL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clka = 1'b0;
  logic       rst_n;
  logic       wrb, wrb3;
  logic [7:0] db_in, db3;
  logic       ready, dout, wra_n, ovf, busy;
  logic       ready3, dout3, wra_n3, ovf3, busy3;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q3[$];
  int         cnt[2];
  logic [8:0] acc[2];

  typedef struct {
    logic [7:0] w;
    logic [8:0] bits;
  } vec_t;
  vec_t tv[5];

  always #5 clka = ~clka;

  pal2sel #(.DW(8), .GAP(1)) dut (
    .clka(clka), .rst_n(rst_n), .wrb(wrb), .db_in(db_in),
    .ready(ready), .dout(dout), .wra_n(wra_n), .ovf(ovf), .busy(busy)
  );

  pal2sel #(.DW(8), .GAP(3)) dut3 (
    .clka(clka), .rst_n(rst_n), .wrb(wrb3), .db_in(db3),
    .ready(ready3), .dout(dout3), .wra_n(wra_n3), .ovf(ovf3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] w);
    if (d == 0) begin
      wrb   = 1'b1;
      db_in = w;
    end else begin
      wrb3 = 1'b1;
      db3  = w;
    end
    tick();
    wrb  = 1'b0;
    wrb3 = 1'b0;
  endtask

  task automatic expect_wra(input int d, input logic v, input int n,
                            input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, (d == 0) ? wra_n : wra_n3, v);
      if (d == 0) check("ovf_quiet", ovf, 1'b0);
    end
  endtask

  task automatic wait_idle(input int d);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (d == 0) done = !busy && ready && wra_n;
      else done = !busy3 && ready3 && wra_n3;
    end
    check("idle_timeout", done, 1'b1);
  endtask

  // Receiver model: rebuild frames from wra_n/dout, pop expected words
  task automatic mon(input int d, input logic wn, input logic dq);
    logic [7:0] got;
    logic [7:0] want;
    if (!wn) begin
      acc[d] = {acc[d][7:0], dq};
      cnt[d]++;
      check("frame_len_max", cnt[d] <= FL, 1'b1);
    end else begin
      check("dout_idle", dq, 1'b0);
      if (cnt[d] != 0) begin
        check("frame_len", cnt[d], FL);
`ifdef PAL2SEL_PARITY_EN
        got = acc[d][8:1];
        check("parity", acc[d][0], ^got);
`else
        got = acc[d][7:0];
`endif
        if (d == 0) begin
          check("sb_nonempty", exp_q0.size() > 0, 1'b1);
          want = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
        end else begin
          check("sb3_nonempty", exp_q3.size() > 0, 1'b1);
          want = (exp_q3.size() > 0) ? exp_q3.pop_front() : 8'hxx;
        end
        check(d == 0 ? "rx_word" : "rx3_word", got, want);
        cnt[d] = 0;
      end
    end
  endtask

  always @(negedge clka) begin
    if (!rst_n) begin
      cnt[0] = 0;
      cnt[1] = 0;
      acc[0] = '0;
      acc[1] = '0;
    end else begin
      mon(0, wra_n, dout);
      mon(1, wra_n3, dout3);
    end
  end

  initial begin
    rst_n = 1'b0;
    wrb   = 1'b0;
    wrb3  = 1'b0;
    db_in = '0;
    db3   = '0;
    // data bits MSB first, then even parity
    tv[0] = '{8'hA5, 9'b10100101_0};
    tv[1] = '{8'h07, 9'b00000111_1};
    tv[2] = '{8'h03, 9'b00000011_0};
    tv[3] = '{8'h80, 9'b10000000_1};
    tv[4] = '{8'h5E, 9'b01011110_1};

    repeat (2) @(posedge clka);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_dout", dout, 1'b0);
    check("rst_wra_n", wra_n, 1'b1);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst3_ready", ready3, 1'b1);
    check("rst3_wra_n", wra_n3, 1'b1);
    check("rst3_busy", busy3, 1'b0);
    rst_n = 1'b1;
    tick();

    // single words, bit by bit
    for (int v = 0; v < 5; v++) begin
      exp_q0.push_back(tv[v].w);
      send(0, tv[v].w);
      check("ld_ready", ready, 1'b0);
      for (int i = 0; i < FL; i++) begin
        tick();
        check("bit_wra", wra_n, 1'b0);
        check("bit_val", dout, tv[v].bits[8-i]);
        if (i == 0) check("ready_back", ready, 1'b1);
      end
      tick();
      check("end_wra", wra_n, 1'b1);
      check("end_dout", dout, 1'b0);
      wait_idle(0);
    end

    // back-to-back frames
    exp_q0.push_back(8'h3C);
    exp_q0.push_back(8'hC3);
    send(0, 8'h3C);
    tick();
    send(0, 8'hC3);
    expect_wra(0, 1'b0, FL - 2, "b2b_f1");
    expect_wra(0, 1'b1, 1, "b2b_gap");
    expect_wra(0, 1'b0, FL, "b2b_f2");
    wait_idle(0);

    // overflow: third word refused while hold is full
    exp_q0.push_back(8'h11);
    exp_q0.push_back(8'h22);
    send(0, 8'h11);
    tick();
    send(0, 8'h22);
    check("ovf_full", ready, 1'b0);
    send(0, 8'h33);
    check("ovf_pulse", ovf, 1'b1);
    tick();
    check("ovf_once", ovf, 1'b0);
    wait_idle(0);

    // mid-frame reset with a word also held
    send(0, 8'hFF);
    tick();
    send(0, 8'h77);
    repeat (2) tick();
    check("pre_rst_wra", wra_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_wra_n", wra_n, 1'b1);
    check("mrst_dout", dout, 1'b0);
    check("mrst_ready", ready, 1'b1);
    check("mrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q0.push_back(8'h81);
    send(0, 8'h81);
    wait_idle(0);

    // GAP=3 instance
    exp_q3.push_back(8'h5A);
    exp_q3.push_back(8'hE7);
    send(1, 8'h5A);
    tick();
    send(1, 8'hE7);
    expect_wra(1, 1'b0, FL - 2, "g3_f1");
    expect_wra(1, 1'b1, 3, "g3_gap");
    expect_wra(1, 1'b0, FL, "g3_f2");
    tick();
    check("g3_end", wra_n3, 1'b1);
    wait_idle(1);

    check("sb_drained", exp_q0.size(), 0);
    check("sb3_drained", exp_q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
